sifh_histogram_builder: RTL and testbench

Accumulates per-pixel TDC time-of-flight histograms into the shared histogram SRAM for one frame, directly upstream of the SiFH peak detector. On `start` it clears the histogram region, then performs a fully pipelined, saturating read-modify-write increment for every accepted TDC event. On `frame_end` it drains the pipeline and pulses `hist_done`, which starts peak detection over the same SRAM.

---
 rtl/sifh_histogram_builder_if.sv | 28 ++
 rtl/sifh_histogram_builder.sv | 135 +++++++++++++
 tb/tb_sifh_histogram_builder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sifh_histogram_builder_if.sv
// TDC event handshake plus histogram SRAM read/write ports shared by the builder and its environment.
interface sifh_histogram_builder_if #(
  parameter int PIX_W   = 2,
  parameter int BIN_W   = 4,
  parameter int ADDR_W  = 6,
  parameter int COUNT_W = 8
);
  logic               tdc_valid;
  logic [PIX_W-1:0]   tdc_pixel;
  logic [BIN_W-1:0]   tdc_bin;
  logic               tdc_ready;
  logic               rEnable;
  logic [ADDR_W-1:0]  raddr;
  logic [COUNT_W-1:0] counts;
  logic               wEnable;
  logic [ADDR_W-1:0]  waddr;
  logic [COUNT_W-1:0] newCounts;

  modport master (
    input  tdc_valid, tdc_pixel, tdc_bin, counts,
    output tdc_ready, rEnable, raddr, wEnable, waddr, newCounts
  );

  modport slave (
    output tdc_valid, tdc_pixel, tdc_bin, counts,
    input  tdc_ready, rEnable, raddr, wEnable, waddr, newCounts
  );
endinterface

// File: rtl/sifh_histogram_builder.sv
// Per-frame TDC histogram accumulation: clears the SRAM region, then does pipelined
// saturating read-modify-write increments with write-to-read forwarding.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_CLEAR | writing 0 to every histogram word, one per cycle
// S_ACCUM | accepting TDC events
// S_DRAIN | letting in-flight increments reach the write port
// S_DONE  | one-cycle hist_done pulse
module sifh_histogram_builder #(
  parameter int PIXEL_NUM = 4,
  parameter int BIN_NUM   = 16,
  parameter int COUNT_W   = 8,
  parameter int ADDR_W    = $clog2(PIXEL_NUM*BIN_NUM),
  parameter int PIX_W     = $clog2(PIXEL_NUM),
  parameter int BIN_W     = $clog2(BIN_NUM)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        frame_end,
  output logic        busy,
  output logic        hist_done,
  output logic [15:0] drop_cnt,
  sifh_histogram_builder_if.master hist
);

  localparam int TOTAL = PIXEL_NUM * BIN_NUM;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  clr_left;
  logic               s1_valid, s2_valid;
  logic [ADDR_W-1:0]  s1_addr, s2_addr;
  logic               pw_valid;
  logic [ADDR_W-1:0]  pw_addr;
  logic [COUNT_W-1:0] pw_data;
  logic               accept, in_range;
  logic [ADDR_W-1:0]  ev_addr;
  logic [COUNT_W-1:0] src_val, inc_val;

  assign accept   = hist.tdc_valid && hist.tdc_ready;
  assign in_range = (int'(hist.tdc_pixel) < PIXEL_NUM) && (int'(hist.tdc_bin) < BIN_NUM);
  assign ev_addr  = ADDR_W'(int'(hist.tdc_pixel) * BIN_NUM + int'(hist.tdc_bin));

  // Read stage is the first pipeline register itself.
  assign hist.rEnable = s1_valid;
  assign hist.raddr   = s1_addr;

  // Newest write wins: the one on the port now, then the one from last cycle
  // (which raced the SRAM read), then the SRAM data.
  always_comb begin
    src_val = hist.counts;
    if (hist.wEnable && hist.waddr == s2_addr)
      src_val = hist.newCounts;
    else if (pw_valid && pw_addr == s2_addr)
      src_val = pw_data;
  end

  assign inc_val = (src_val == CNT_MAX) ? CNT_MAX : src_val + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_left == '0) state_nxt = S_ACCUM;
      S_ACCUM: if (frame_end) state_nxt = S_DRAIN;
      S_DRAIN: if (!s1_valid && !s2_valid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.tdc_ready <= 1'b0;
      hist.wEnable   <= 1'b0;
      hist.waddr     <= '0;
      hist.newCounts <= '0;
      busy           <= 1'b0;
      hist_done      <= 1'b0;
      drop_cnt       <= '0;
      clr_left       <= '0;
      s1_valid       <= 1'b0;
      s1_addr        <= '0;
      s2_valid       <= 1'b0;
      s2_addr        <= '0;
      pw_valid       <= 1'b0;
      pw_addr        <= '0;
      pw_data        <= '0;
    end else begin
      hist.tdc_ready <= (state_nxt == S_ACCUM);
      busy           <= (state_nxt != S_IDLE);
      hist_done      <= (state_nxt == S_DONE);

      s1_valid <= accept && in_range;
      if (accept && in_range) s1_addr <= ev_addr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;

      pw_valid <= hist.wEnable;
      pw_addr  <= hist.waddr;
      pw_data  <= hist.newCounts;

      if (state == S_IDLE && start) begin
        clr_left <= ADDR_W'(TOTAL - 1);
        drop_cnt <= '0;
      end
      if (state == S_CLEAR) clr_left <= clr_left - 1'b1;

      if (state_nxt == S_CLEAR) begin
        hist.wEnable   <= 1'b1;
        hist.waddr     <= (state == S_CLEAR) ? hist.waddr + 1'b1 : '0;
        hist.newCounts <= '0;
      end else begin
        hist.wEnable <= s2_valid;
        if (s2_valid) begin
          hist.waddr     <= s2_addr;
          hist.newCounts <= inc_val;
        end
      end

      if (accept && !in_range && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sifh_histogram_builder.sv
// Directed bench for sifh_histogram_builder with a behavioural one-cycle-latency SRAM.
module tb_sifh_histogram_builder;
  localparam int PIXEL_NUM = 4;
  localparam int BIN_NUM   = 16;
  localparam int COUNT_W   = 8;
  localparam int ADDR_W    = 6;
  localparam int PIX_W     = 3;
  localparam int BIN_W     = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        frame_end = 1'b0;
  logic        busy, hist_done;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  int rd_count = 0;
  int r0, w0;
  logic [COUNT_W-1:0] mem [0:63];

  sifh_histogram_builder_if #(.PIX_W(PIX_W), .BIN_W(BIN_W), .ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) hif ();

  sifh_histogram_builder #(
    .PIXEL_NUM(PIXEL_NUM), .BIN_NUM(BIN_NUM), .COUNT_W(COUNT_W),
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .BIN_W(BIN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_end(frame_end),
    .busy(busy), .hist_done(hist_done), .drop_cnt(drop_cnt), .hist(hif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (hif.rEnable) begin
      hif.counts <= mem[hif.raddr];
      rd_count   <= rd_count + 1;
    end
    if (hif.wEnable) begin
      mem[hif.waddr] <= hif.newCounts;
      wr_count       <= wr_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      check_val("clear_wr", {hif.wEnable, hif.waddr, hif.newCounts, hif.tdc_ready},
                {1'b1, 6'(i), 8'h00, 1'b0});
    end
    @(negedge clk);
    check_val("ready_after_clear", {hif.tdc_ready, hif.wEnable, busy}, 3'b101);
  endtask

  task automatic send(input logic [PIX_W-1:0] p, input logic [BIN_W-1:0] b);
    hif.tdc_valid = 1'b1;
    hif.tdc_pixel = p;
    hif.tdc_bin   = b;
    @(negedge clk);
    hif.tdc_valid = 1'b0;
  endtask

  task automatic end_frame(input bit ev, input logic [PIX_W-1:0] p, input logic [BIN_W-1:0] b);
    bit found;
    found = 1'b0;
    hif.tdc_valid = ev;
    hif.tdc_pixel = p;
    hif.tdc_bin   = b;
    frame_end     = 1'b1;
    @(negedge clk);
    hif.tdc_valid = 1'b0;
    frame_end     = 1'b0;
    check_val("ready_drop", hif.tdc_ready, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      if (hist_done) begin
        found = 1'b1;
        break;
      end
    end
    check_val("done_latency", found, 1'b1);
    @(negedge clk);
    check_val("idle_after_done", {busy, hist_done}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'hAA;
    hif.tdc_valid = 1'b0;
    hif.tdc_pixel = '0;
    hif.tdc_bin   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", {hif.tdc_ready, hif.rEnable, hif.raddr, hif.wEnable, hif.waddr,
                             hif.newCounts, busy, hist_done, drop_cnt}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // frame_end in IDLE must not start anything
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    check_val("fe_in_idle", {busy, hif.tdc_ready, hif.wEnable}, 3'b000);

    // Frame 1: clear, ignored start, single event timing
    start_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("start_in_accum", {hif.tdc_ready, hif.wEnable}, 2'b10);
    send(3'd2, 5'd5);
    check_val("single_rd", {hif.rEnable, hif.raddr}, {1'b1, 6'd37});
    @(negedge clk);
    @(negedge clk);
    check_val("single_wr", {hif.wEnable, hif.waddr, hif.newCounts}, {1'b1, 6'd37, 8'd1});
    end_frame(1'b0, '0, '0);
    check_val("mem37", mem[37], 8'd1);

    // Frame 2: re-clear, last address, back-to-back hazards, event on frame_end
    start_clear();
    check_val("mem37_recleared", mem[37], 8'd0);
    send(3'd3, 5'd15);
    for (int i = 0; i < 5; i++) send(3'd0, 5'd3);
    send(3'd1, 5'd0);
    send(3'd0, 5'd3);
    send(3'd1, 5'd0);
    end_frame(1'b1, 3'd0, 5'd3);
    check_val("mem3_hazard", mem[3], 8'd7);
    check_val("mem16_hazard", mem[16], 8'd2);
    check_val("mem63_last", mem[63], 8'd1);
    check_val("mem0_untouched", mem[0], 8'd0);

    // Frame 3: saturation then out-of-range drops
    start_clear();
    for (int i = 0; i < 300; i++) send(3'd0, 5'd9);
    repeat (4) @(negedge clk);
    r0 = rd_count;
    w0 = wr_count;
    send(3'd5, 5'd2);
    send(3'd1, 5'd20);
    repeat (4) @(negedge clk);
    check_val("drop_no_rd", rd_count, r0);
    check_val("drop_no_wr", wr_count, w0);
    check_val("drop_cnt", drop_cnt, 16'd2);
    end_frame(1'b0, '0, '0);
    check_val("mem9_sat", mem[9], 8'd255);
    check_val("mem8_zero", mem[8], 8'd0);
    check_val("mem10_zero", mem[10], 8'd0);
    check_val("drop_cnt_held", drop_cnt, 16'd2);

    // Frame 4: reset with two events in flight
    start_clear();
    check_val("drop_cleared", drop_cnt, 16'd0);
    send(3'd1, 5'd1);
    send(3'd1, 5'd1);
    rst_n = 1'b0;
    #1;
    check_val("reset_async", {hif.tdc_ready, hif.rEnable, hif.raddr, hif.wEnable, hif.waddr,
                              hif.newCounts, busy, hist_done, drop_cnt}, 64'd0);
    w0 = wr_count;
    repeat (3) @(negedge clk);
    check_val("reset_no_wr", wr_count, w0);
    check_val("mem17_no_wr", mem[17], 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_clear();
    send(3'd1, 5'd1);
    end_frame(1'b0, '0, '0);
    check_val("mem17_after_reset", mem[17], 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
